// File: rtl/instr_arb_pkg.sv
// Shared types and default parameters for the instruction RAM arbiter.
package instr_arb_pkg;

    localparam int unsigned ARB_ADDR_WIDTH = 15;
    localparam int unsigned ARB_MAX_WAIT   = 8;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        CORE = 2'd1,
        DBG  = 2'd2
    } owner_e;

    typedef enum logic {
        CORE_PRIO  = 1'b0,
        DBG_FORCED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/instr_arb_wait_cnt.sv
// Saturating starvation counter for the loader port. sat_o flags the edge on
// which the count reaches MAX_WAIT, so priority flips in time for the next cycle.
module instr_arb_wait_cnt #(
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(MAX_WAIT - 1);

    logic [CNT_W-1:0] cnt_r;

    // Count denied loader cycles, hold at MAX_WAIT, clear on grant or idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr_i) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (inc_i && (cnt_r != MAX_C)) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign sat_o = inc_i && !clr_i && (cnt_r >= LAST_C);

endmodule

// File: rtl/instr_ram_arbiter.sv
// Core/loader arbiter in front of instr_ram_wrap with a starvation guard.
// Optional INSTR_ARB_BOOT_PROTECT_EN: loader writes to the boot region are rejected.
module instr_ram_arbiter
    import instr_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ARB_ADDR_WIDTH,
    parameter int unsigned MAX_WAIT   = ARB_MAX_WAIT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  core_req_i,
    input  logic [ADDR_WIDTH-1:0] core_addr_i,
    output logic                  core_gnt_o,
    output logic                  core_rvalid_o,
    output logic [31:0]           core_rdata_o,
    input  logic                  dbg_req_i,
    input  logic                  dbg_we_i,
    input  logic [3:0]            dbg_be_i,
    input  logic [ADDR_WIDTH-1:0] dbg_addr_i,
    input  logic [31:0]           dbg_wdata_i,
    output logic                  dbg_gnt_o,
    output logic                  dbg_rvalid_o,
    output logic [31:0]           dbg_rdata_o,
    output logic                  dbg_err_o,
    output logic                  ram_en_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [31:0]           ram_wdata_o,
    output logic                  ram_we_o,
    output logic [3:0]            ram_be_o,
    input  logic [31:0]           ram_rdata_i
);

    arb_state_e state_r, state_nxt_s;
    owner_e     owner_r, owner_nxt_s;
    logic       core_gnt_s, dbg_gnt_s, sat_s, boot_wr_s;

    instr_arb_wait_cnt #(.MAX_WAIT(MAX_WAIT)) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (dbg_req_i & ~dbg_gnt_s),
        .clr_i (dbg_gnt_s | ~dbg_req_i),
        .sat_o (sat_s)
    );

`ifdef INSTR_ARB_BOOT_PROTECT_EN
    logic err_r;

    assign boot_wr_s = dbg_we_i & ~dbg_addr_i[ADDR_WIDTH-1];

    // Rejected boot-region write is flagged alongside its response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else begin
            err_r <= dbg_gnt_s & boot_wr_s;
        end
    end

    assign dbg_err_o = err_r;
`else
    assign boot_wr_s = 1'b0;
    assign dbg_err_o = 1'b0;
`endif

    // Winner selection; the loader overrides the core only in DBG_FORCED
    always_comb begin
        core_gnt_s = 1'b0;
        dbg_gnt_s  = 1'b0;
        if (core_req_i && dbg_req_i) begin
            if (state_r == DBG_FORCED) begin
                dbg_gnt_s = 1'b1;
            end else begin
                core_gnt_s = 1'b1;
            end
        end else if (core_req_i) begin
            core_gnt_s = 1'b1;
        end else if (dbg_req_i) begin
            dbg_gnt_s = 1'b1;
        end else begin
            core_gnt_s = 1'b0;
        end
    end

    // Priority state: forced loader slot lasts for a single grant
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            CORE_PRIO: begin
                if (sat_s) begin
                    state_nxt_s = DBG_FORCED;
                end else begin
                    state_nxt_s = CORE_PRIO;
                end
            end
            DBG_FORCED: begin
                if (dbg_gnt_s || !dbg_req_i) begin
                    state_nxt_s = CORE_PRIO;
                end else begin
                    state_nxt_s = DBG_FORCED;
                end
            end
            default: state_nxt_s = CORE_PRIO;
        endcase
    end

    // Response routing follows whoever was granted last cycle
    always_comb begin
        owner_nxt_s = NONE;
        if (core_gnt_s) begin
            owner_nxt_s = CORE;
        end else if (dbg_gnt_s) begin
            owner_nxt_s = DBG;
        end else begin
            owner_nxt_s = NONE;
        end
    end

    // State and owner registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= CORE_PRIO;
            owner_r <= NONE;
        end else begin
            state_r <= state_nxt_s;
            owner_r <= owner_nxt_s;
        end
    end

    // Downstream bus carries the winner's fields, zero otherwise
    always_comb begin
        ram_en_o    = 1'b0;
        ram_addr_o  = {ADDR_WIDTH{1'b0}};
        ram_wdata_o = 32'h0000_0000;
        ram_we_o    = 1'b0;
        ram_be_o    = 4'h0;
        if (core_gnt_s) begin
            ram_en_o   = 1'b1;
            ram_addr_o = core_addr_i;
            ram_be_o   = 4'hF;
        end else if (dbg_gnt_s && !boot_wr_s) begin
            ram_en_o    = 1'b1;
            ram_addr_o  = dbg_addr_i;
            ram_wdata_o = dbg_wdata_i;
            ram_we_o    = dbg_we_i;
            ram_be_o    = dbg_be_i;
        end else begin
            ram_en_o = 1'b0;
        end
    end

    assign core_gnt_o    = core_gnt_s;
    assign dbg_gnt_o     = dbg_gnt_s;
    assign core_rvalid_o = (owner_r == CORE);
    assign dbg_rvalid_o  = (owner_r == DBG);
    assign core_rdata_o  = ram_rdata_i;
    assign dbg_rdata_o   = ram_rdata_i;

endmodule

// File: tb/tb_instr_ram_arbiter.sv
// Directed bench for instr_ram_arbiter with a behavioural RAM and a response scoreboard.
module tb_instr_ram_arbiter;

    localparam int AW = 15;
`ifdef INSTR_ARB_BOOT_PROTECT_EN
    localparam bit BOOT_PROT = 1'b1;
`else
    localparam bit BOOT_PROT = 1'b0;
`endif

    typedef struct {
        logic        core;
        logic        dbg;
        logic        err;
        logic        chk_data;
        logic [31:0] data;
    } resp_t;

    logic          clk;
    logic          rst_n;
    logic          core_req;
    logic [AW-1:0] core_addr;
    logic          core_gnt_o, core_rvalid_o;
    logic [31:0]   core_rdata_o;
    logic          dbg_req, dbg_we;
    logic [3:0]    dbg_be;
    logic [AW-1:0] dbg_addr;
    logic [31:0]   dbg_wdata;
    logic          dbg_gnt_o, dbg_rvalid_o, dbg_err_o;
    logic [31:0]   dbg_rdata_o;
    logic          ram_en_o, ram_we_o;
    logic [AW-1:0] ram_addr_o;
    logic [31:0]   ram_wdata_o;
    logic [3:0]    ram_be_o;
    logic [31:0]   ram_rdata;

    int n_pass = 0;
    int n_chk  = 0;

    resp_t       sb[$];
    logic [31:0] ref_mem [int];
    bit   [31:0] env_mem   [0:32767];
    bit          env_valid [0:32767];

    instr_ram_arbiter #(.ADDR_WIDTH(AW), .MAX_WAIT(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .core_req_i    (core_req),
        .core_addr_i   (core_addr),
        .core_gnt_o    (core_gnt_o),
        .core_rvalid_o (core_rvalid_o),
        .core_rdata_o  (core_rdata_o),
        .dbg_req_i     (dbg_req),
        .dbg_we_i      (dbg_we),
        .dbg_be_i      (dbg_be),
        .dbg_addr_i    (dbg_addr),
        .dbg_wdata_i   (dbg_wdata),
        .dbg_gnt_o     (dbg_gnt_o),
        .dbg_rvalid_o  (dbg_rvalid_o),
        .dbg_rdata_o   (dbg_rdata_o),
        .dbg_err_o     (dbg_err_o),
        .ram_en_o      (ram_en_o),
        .ram_addr_o    (ram_addr_o),
        .ram_wdata_o   (ram_wdata_o),
        .ram_we_o      (ram_we_o),
        .ram_be_o      (ram_be_o),
        .ram_rdata_i   (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int a);
        logic [31:0] v;
        v = 32'hC0DE_0000 | 32'(a);
        if (a == 32'h4020) v = 32'h0;
        return v;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] w, input logic [3:0] be);
        logic [31:0] v;
        v = old;
        for (int b = 0; b < 4; b++) if (be[b]) v[8*b +: 8] = w[8*b +: 8];
        return v;
    endfunction

    function automatic logic [31:0] env_read(input int a);
        return env_valid[a] ? env_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] ref_read(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    // Behavioural stand-in for instr_ram_wrap: one-cycle read latency, byte writes
    always @(posedge clk) begin
        if (ram_en_o) begin
            ram_rdata <= env_read(int'(ram_addr_o));
            if (ram_we_o) begin
                env_mem[ram_addr_o]   <= merge(env_read(int'(ram_addr_o)), ram_wdata_o, ram_be_o);
                env_valid[ram_addr_o] <= 1'b1;
            end
        end
    end

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with inputs already driven; checks grant/bus, then the response
    task automatic step(input logic ecg, input logic edg, input logic een, input string tag);
        resp_t r, got;
        r = '{core: 1'b0, dbg: 1'b0, err: 1'b0, chk_data: 1'b0, data: 32'h0};
        #1;
        chk(core_gnt_o, ecg, {tag, "/core_gnt"});
        chk(dbg_gnt_o, edg, {tag, "/dbg_gnt"});
        chk(ram_en_o, een, {tag, "/ram_en"});
        if (ecg) begin
            chk(ram_addr_o, core_addr, {tag, "/ram_addr"});
            chk(ram_we_o, 1'b0, {tag, "/ram_we"});
            chk(ram_be_o, 4'hF, {tag, "/ram_be"});
            chk(ram_wdata_o, 32'h0, {tag, "/ram_wdata"});
            r.core = 1'b1; r.chk_data = 1'b1; r.data = ref_read(int'(core_addr));
        end else if (edg) begin
            r.dbg = 1'b1;
            if (een) begin
                chk(ram_addr_o, dbg_addr, {tag, "/ram_addr"});
                chk(ram_we_o, dbg_we, {tag, "/ram_we"});
                chk(ram_be_o, dbg_be, {tag, "/ram_be"});
                chk(ram_wdata_o, dbg_wdata, {tag, "/ram_wdata"});
            end
            if (dbg_we) begin
                if (BOOT_PROT && !dbg_addr[AW-1]) r.err = 1'b1;
                else ref_mem[int'(dbg_addr)] = merge(ref_read(int'(dbg_addr)), dbg_wdata, dbg_be);
            end else begin
                r.chk_data = 1'b1; r.data = ref_read(int'(dbg_addr));
            end
        end else begin
            chk({ram_we_o, ram_be_o, ram_addr_o}, 32'h0, {tag, "/idle_bus"});
            chk(ram_wdata_o, 32'h0, {tag, "/idle_wdata"});
        end
        sb.push_back(r);
        @(posedge clk);
        @(negedge clk);
        got = sb.pop_front();
        chk(core_rvalid_o, got.core, {tag, "/core_rvalid"});
        chk(dbg_rvalid_o, got.dbg, {tag, "/dbg_rvalid"});
        chk(dbg_err_o, got.err, {tag, "/dbg_err"});
        if (got.chk_data && got.core) chk(core_rdata_o, got.data, {tag, "/core_rdata"});
        if (got.chk_data && got.dbg) chk(dbg_rdata_o, got.data, {tag, "/dbg_rdata"});
    endtask

    initial begin
        rst_n = 1'b0; core_req = 1'b0; core_addr = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_be = 4'h0; dbg_addr = '0; dbg_wdata = 32'h0;
        @(negedge clk);
        #1;
        chk(core_rvalid_o, 1'b0, "rst/core_rvalid");
        chk(dbg_rvalid_o, 1'b0, "rst/dbg_rvalid");
        chk(dbg_err_o, 1'b0, "rst/dbg_err");
        chk(ram_en_o, 1'b0, "rst/ram_en");
        @(negedge clk);
        rst_n = 1'b1;

        // Core only, three back-to-back fetches
        core_req = 1'b1; core_addr = 15'h4010;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, $sformatf("core%0d", i));
        core_req = 1'b0;
        step(1'b0, 1'b0, 1'b0, "idle0");

        // Loader partial write then read-back
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_be = 4'b0011; dbg_addr = 15'h4020; dbg_wdata = 32'hDEAD_BEEF;
        step(1'b0, 1'b1, 1'b1, "dbg_wr");
        dbg_we = 1'b0; dbg_be = 4'hF; dbg_wdata = 32'h0;
        step(1'b0, 1'b1, 1'b1, "dbg_rd");
        chk(dbg_rdata_o, 32'h0000_BEEF, "dbg_rd/beef");
        dbg_req = 1'b0;

        // Continuous contention: loader wins every 9th cycle
        core_req = 1'b1; dbg_req = 1'b1;
        for (int i = 0; i < 20; i++)
            step((i % 9) != 8, (i % 9) == 8, 1'b1, $sformatf("starve%0d", i));
        core_req = 1'b0; dbg_req = 1'b0;
        step(1'b0, 1'b0, 1'b0, "idle1");

        // Loader write into the boot region, then read it back
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_be = 4'hF; dbg_addr = 15'h0100; dbg_wdata = 32'h1234_5678;
        step(1'b0, 1'b1, !BOOT_PROT, "boot_wr");
        dbg_we = 1'b0;
        step(1'b0, 1'b1, 1'b1, "boot_rd");
        dbg_req = 1'b0;
        step(1'b0, 1'b0, 1'b0, "idle2");

        // Partial starvation count, then reset while a core response is due
        core_req = 1'b1; core_addr = 15'h4011; dbg_req = 1'b1; dbg_addr = 15'h4020;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, $sformatf("prerst%0d", i));
        #1;
        chk(core_gnt_o, 1'b1, "rst_mid/core_gnt");
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk(core_rvalid_o, 1'b0, "rst_mid/core_rvalid");
        chk(dbg_rvalid_o, 1'b0, "rst_mid/dbg_rvalid");
        core_req = 1'b0; dbg_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, "postrst0");
        step(1'b0, 1'b0, 1'b0, "postrst1");
        core_req = 1'b1; dbg_req = 1'b1;
        for (int i = 0; i < 10; i++)
            step(i != 8, i == 8, 1'b1, $sformatf("poststarve%0d", i));
        core_req = 1'b0; dbg_req = 1'b0;
        step(1'b0, 1'b0, 1'b0, "idle3");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
